// File: rtl/c_add_sched.sv
// Round-robin scheduler sharing one n-input adder among num_reqs requesters,
// with a single-entry result slot. Optional per-requester accumulators: C_ADD_SCHED_ACCUM_EN.

module c_add_nto1 #(
    parameter int width     = 1,
    parameter int num_ports = 2,
    parameter int out_width = $clog2(num_ports * ((1 << width) - 1) + 1)
) (
    input  logic [0:num_ports*width-1] data_in,
    output logic [0:out_width-1]       data_out
);
    always_comb begin
        data_out = '0;
        for (int p = 0; p < num_ports; p++) begin
            data_out = data_out + out_width'(data_in[p*width +: width]);
        end
    end
endmodule

module c_add_sched #(
    parameter int width     = 1,
    parameter int num_ports = 2,
    parameter int num_reqs  = 4,
    parameter int acc_width = 16,
    localparam int out_width = $clog2(num_ports * ((1 << width) - 1) + 1),
    localparam int id_width  = (num_reqs > 1) ? $clog2(num_reqs) : 1,
`ifdef C_ADD_SCHED_ACCUM_EN
    localparam int res_width = acc_width
`else
    localparam int res_width = out_width
`endif
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [0:num_reqs-1]                req,
    input  logic [0:num_reqs*num_ports*width-1] data_in,
    output logic [0:num_reqs-1]                gnt,
    input  logic                               res_ready,
    output logic                               res_valid,
    output logic [0:id_width-1]                res_id,
    output logic [0:res_width-1]               res_data
`ifdef C_ADD_SCHED_ACCUM_EN
    ,
    input  logic [0:num_reqs-1]                acc_clr
`endif
);
    localparam int vec_width = num_ports * width;

    // res_valid is the slot state itself: FULL means a result is being held.
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [id_width-1:0]     ptr_q, ptr_d;
    logic [0:id_width-1]     res_id_q, res_id_d;
    logic [0:res_width-1]    res_data_q, res_data_d;

    logic [id_width-1:0]     win;
    logic                    found;
    logic                    slot_free;
    logic                    grant;
    int                      idx;
    logic [0:vec_width-1]    sel_data;
    logic [0:out_width-1]    sum;

    // Round-robin search starting at ptr, wrapping modulo num_reqs.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < num_reqs; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= num_reqs) begin
                idx = idx - num_reqs;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = id_width'(idx);
            end
        end
    end

    assign slot_free = (state_q == EMPTY) || res_ready;
    assign grant     = reset && found && slot_free;

    always_comb begin
        gnt = '0;
        if (grant) begin
            gnt[win] = 1'b1;
        end
    end

    assign sel_data = data_in[win*vec_width +: vec_width];

    c_add_nto1 #(
        .width     (width),
        .num_ports (num_ports),
        .out_width (out_width)
    ) u_add (
        .data_in  (sel_data),
        .data_out (sum)
    );

`ifdef C_ADD_SCHED_ACCUM_EN
    logic [acc_width-1:0] acc_q [num_reqs];
    logic [acc_width-1:0] acc_d [num_reqs];
    logic [acc_width-1:0] acc_new;

    // A clear coinciding with a grant restarts the accumulator from this sum.
    always_comb begin
        acc_new = (acc_clr[win] ? '0 : acc_q[win]) + acc_width'(sum);
        for (int i = 0; i < num_reqs; i++) begin
            acc_d[i] = acc_clr[i] ? '0 : acc_q[i];
            if (grant && (win == id_width'(i))) begin
                acc_d[i] = acc_new;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < num_reqs; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < num_reqs; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        res_id_d   = res_id_q;
        res_data_d = res_data_q;
        if (grant) begin
            state_d  = FULL;
            ptr_d    = (win == id_width'(num_reqs - 1)) ? '0 : win + 1'b1;
            res_id_d = win;
`ifdef C_ADD_SCHED_ACCUM_EN
            res_data_d = acc_new;
`else
            res_data_d = sum;
`endif
        end else if (state_q == FULL && res_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= EMPTY;
            ptr_q      <= '0;
            res_id_q   <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            res_id_q   <= res_id_d;
            res_data_q <= res_data_d;
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_id    = res_id_q;
    assign res_data  = res_data_q;
endmodule

// File: tb/tb_c_add_sched.sv
// Directed bench for c_add_sched at width=4, num_ports=2, num_reqs=4.
// Accumulator scenarios run instead of the plain ones when C_ADD_SCHED_ACCUM_EN is defined.

module tb_c_add_sched;
    localparam int W  = 4;
    localparam int NP = 2;
    localparam int NR = 4;
`ifdef C_ADD_SCHED_ACCUM_EN
    localparam int RW = 16;
`else
    localparam int RW = 5;
`endif

    logic              clk;
    logic              reset;
    logic [0:NR-1]     req;
    logic [0:NR*NP*W-1] data_in;
    logic [0:NR-1]     gnt;
    logic              res_ready;
    logic              res_valid;
    logic [0:1]        res_id;
    logic [0:RW-1]     res_data;

    int n_pass;
    int n_total;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef C_ADD_SCHED_ACCUM_EN
    logic [0:NR-1] acc_clr;
    logic [0:NR-1] gnt4;
    logic          res_valid4;
    logic [0:1]    res_id4;
    logic [0:3]    res_data4;

    c_add_sched #(.width(W), .num_ports(NP), .num_reqs(NR), .acc_width(16)) dut (
        .clk(clk), .reset(reset), .req(req), .data_in(data_in), .gnt(gnt),
        .res_ready(res_ready), .res_valid(res_valid), .res_id(res_id),
        .res_data(res_data), .acc_clr(acc_clr)
    );

    c_add_sched #(.width(W), .num_ports(NP), .num_reqs(NR), .acc_width(4)) dut4 (
        .clk(clk), .reset(reset), .req(req), .data_in(data_in), .gnt(gnt4),
        .res_ready(res_ready), .res_valid(res_valid4), .res_id(res_id4),
        .res_data(res_data4), .acc_clr(acc_clr)
    );
`else
    c_add_sched #(.width(W), .num_ports(NP), .num_reqs(NR)) dut (
        .clk(clk), .reset(reset), .req(req), .data_in(data_in), .gnt(gnt),
        .res_ready(res_ready), .res_valid(res_valid), .res_id(res_id),
        .res_data(res_data)
    );
`endif

    // ---------------- driver tasks ----------------
    task automatic set_ops(input int r, input int a, input int b);
        logic [3:0] av;
        logic [3:0] bv;
        av = a[3:0];
        bv = b[3:0];
        data_in[r*NP*W +: W]     = av;
        data_in[r*NP*W + W +: W] = bv;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

`ifndef C_ADD_SCHED_ACCUM_EN
    task automatic test_reset();
        req       = 4'b1111;
        res_ready = 1'b1;
        reset     = 1'b0;
        #2;
        n_total++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt); else n_pass++;
        n_total++; if (res_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", res_valid); else n_pass++;
        n_total++; if (res_id !== 2'd0) $display("FAIL reset_id: got %0d want 0", res_id); else n_pass++;
        n_total++; if (res_data !== 5'd0) $display("FAIL reset_data: got %0d want 0", res_data); else n_pass++;
        @(negedge clk);
        req   = 4'b0000;
        reset = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        set_ops(0, 3, 5);
        req       = 4'b1000;
        res_ready = 1'b1;
        #1;
        n_total++; if (gnt !== 4'b1000) $display("FAIL single_gnt: got %b want 1000", gnt); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (res_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", res_valid); else n_pass++;
        n_total++; if (res_id !== 2'd0) $display("FAIL single_id: got %0d want 0", res_id); else n_pass++;
        n_total++; if (res_data !== 5'd8) $display("FAIL single_data: got %0d want 8", res_data); else n_pass++;
        @(negedge clk);
        req = 4'b0000;
        #1;
        n_total++; if (gnt !== 4'b0000) $display("FAIL idle_gnt: got %b want 0000", gnt); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (res_valid !== 1'b0) $display("FAIL drain_valid: got %b want 0", res_valid); else n_pass++;
        n_total++; if (res_data !== 5'd8) $display("FAIL drain_data_hold: got %0d want 8", res_data); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [4:0] sums [4];
        logic [3:0] one;
        logic [3:0] exp_g;
        int         e;
        sums[0] = 5'd8; sums[1] = 5'd3; sums[2] = 5'd16; sums[3] = 5'd30;
        one = 4'b1000;
        pulse_reset();
        set_ops(0, 3, 5);
        set_ops(1, 1, 2);
        set_ops(2, 7, 9);
        set_ops(3, 15, 15);
        req       = 4'b1111;
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            e     = i % NR;
            exp_g = one >> e;
            #1;
            n_total++; if (gnt !== exp_g) $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt, exp_g); else n_pass++;
            @(posedge clk); #1;
            n_total++; if (res_valid !== 1'b1) $display("FAIL rr_valid[%0d]: got %b want 1", i, res_valid); else n_pass++;
            n_total++; if (res_id !== e[1:0]) $display("FAIL rr_id[%0d]: got %0d want %0d", i, res_id, e); else n_pass++;
            n_total++; if (res_data !== sums[e]) $display("FAIL rr_data[%0d]: got %0d want %0d", i, res_data, sums[e]); else n_pass++;
            @(negedge clk);
        end
    endtask

    // Entered with the slot holding id 0 / 8 and ptr at 1.
    task automatic test_stall();
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++; if (gnt !== 4'b0000) $display("FAIL stall_gnt[%0d]: got %b want 0000", i, gnt); else n_pass++;
            @(posedge clk); #1;
            n_total++; if (res_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b want 1", i, res_valid); else n_pass++;
            n_total++; if (res_id !== 2'd0) $display("FAIL stall_id[%0d]: got %0d want 0", i, res_id); else n_pass++;
            n_total++; if (res_data !== 5'd8) $display("FAIL stall_data[%0d]: got %0d want 8", i, res_data); else n_pass++;
            @(negedge clk);
        end
        res_ready = 1'b1;
        #1;
        n_total++; if (gnt !== 4'b0100) $display("FAIL unstall_gnt: got %b want 0100", gnt); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (res_id !== 2'd1) $display("FAIL unstall_id: got %0d want 1", res_id); else n_pass++;
        n_total++; if (res_data !== 5'd3) $display("FAIL unstall_data: got %0d want 3", res_data); else n_pass++;
    endtask

    // ptr is 2 here; granting requester 2 leaves ptr at 3.
    task automatic test_max();
        @(negedge clk);
        set_ops(2, 15, 15);
        req = 4'b0010;
        #1;
        n_total++; if (gnt !== 4'b0010) $display("FAIL max_gnt: got %b want 0010", gnt); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (res_id !== 2'd2) $display("FAIL max_id: got %0d want 2", res_id); else n_pass++;
        n_total++; if (res_data !== 5'd30) $display("FAIL max_data: got %0d want 30", res_data); else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req   = 4'b1111;
        reset = 1'b0;
        #1;
        n_total++; if (res_valid !== 1'b0) $display("FAIL rmid_valid: got %b want 0", res_valid); else n_pass++;
        n_total++; if (res_id !== 2'd0) $display("FAIL rmid_id: got %0d want 0", res_id); else n_pass++;
        n_total++; if (res_data !== 5'd0) $display("FAIL rmid_data: got %0d want 0", res_data); else n_pass++;
        n_total++; if (gnt !== 4'b0000) $display("FAIL rmid_gnt: got %b want 0000", gnt); else n_pass++;
        reset = 1'b1;
        #1;
        n_total++; if (gnt !== 4'b1000) $display("FAIL rmid_first_gnt: got %b want 1000", gnt); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (res_id !== 2'd0) $display("FAIL rmid_first_id: got %0d want 0", res_id); else n_pass++;
        n_total++; if (res_data !== 5'd8) $display("FAIL rmid_first_data: got %0d want 8", res_data); else n_pass++;
        @(negedge clk);
        req = 4'b0000;
    endtask
`else
    task automatic test_accum();
        logic [15:0] exp16;
        logic [3:0]  exp4 [2];
        exp4[0] = 4'd8;
        exp4[1] = 4'd0;
        acc_clr   = 4'b0000;
        res_ready = 1'b1;
        req       = 4'b0000;
        reset     = 1'b0;
        #2;
        n_total++; if (res_data !== 16'd0) $display("FAIL acc_reset_data: got %0d want 0", res_data); else n_pass++;
        pulse_reset();
        set_ops(0, 3, 5);
        req = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            exp16 = 16'(8 * (k + 1));
            @(posedge clk); #1;
            n_total++; if (res_data !== exp16) $display("FAIL acc_sum[%0d]: got %0d want %0d", k, res_data, exp16); else n_pass++;
            if (k < 2) begin
                n_total++; if (res_data4 !== exp4[k]) $display("FAIL acc4_wrap[%0d]: got %0d want %0d", k, res_data4, exp4[k]); else n_pass++;
            end
            @(negedge clk);
        end
        acc_clr = 4'b1000;
        @(posedge clk); #1;
        n_total++; if (res_data !== 16'd8) $display("FAIL acc_clr_grant: got %0d want 8", res_data); else n_pass++;
        n_total++; if (res_id !== 2'd0) $display("FAIL acc_clr_id: got %0d want 0", res_id); else n_pass++;
        @(negedge clk);
        acc_clr = 4'b0000;
        req     = 4'b0000;
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        n_pass    = 0;
        n_total   = 0;
        reset     = 1'b0;
        req       = '0;
        data_in   = '0;
        res_ready = 1'b1;
`ifdef C_ADD_SCHED_ACCUM_EN
        acc_clr   = '0;
        test_accum();
`else
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_max();
        test_reset_mid();
`endif
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/c_add_sched.md
C_ADD_SCHED -- requirements
Module: c_add_sched

Interface
REQ-001 The module SHALL expose parameter width, default 1, bit width of each operand.
REQ-002 The module SHALL expose parameter num_ports, default 2, operands per requester vector.
REQ-003 The module SHALL expose parameter num_reqs, default 4, number of requesters sharing the adder.
REQ-004 The module SHALL expose parameter acc_width, default 16, accumulator width (used only with C_ADD_SCHED_ACCUM_EN).
REQ-005 The module SHALL derive the following local widths:
- out_width = clogb(num_ports*(2^width-1)+1).
- id_width = max(1, clogb(num_reqs)).
- res_width = acc_width with the macro defined, out_width otherwise.
REQ-006 The module SHALL have these ports, clock and reset first:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  [0:num_reqs-1]  per-requester request.
- data_in  input  [0:num_reqs*num_ports*width-1]  requester r owns slice [r*num_ports*width +: num_ports*width]; operand p is at [p*width +: width] within that slice.
- gnt  output  [0:num_reqs-1]  one-hot grant, combinational.
- res_ready  input  1  consumer accepts result.
- res_valid  output  1  result held.
- res_id  output  [0:id_width-1]  requester index of the result.
- res_data  output  [0:res_width-1]  result value.
- acc_clr  input  [0:num_reqs-1]  per-requester accumulator clear; present only with the macro.

Function
REQ-007 Summation SHALL use one shared instance of the team's n-input adder (c_add_nto1): unsigned sum of the granted requester's num_ports operands, zero-extended to out_width, never overflowing.
REQ-008 Output slot FSM SHALL have two states, keyed by res_valid:
- EMPTY: res_valid=0.
- FULL: res_valid=1.
- slot_free = EMPTY, or FULL with res_ready=1.
REQ-009 gnt SHALL be nonzero only when slot_free=1 and req is nonzero; at most one bit is set.
REQ-010 The winner SHALL be the first requester with req set, searching from pointer ptr upward modulo num_reqs (round-robin).
REQ-011 On a grant to requester i, ptr SHALL become (i+1) mod num_reqs at the next edge; with no grant, ptr SHALL hold.
REQ-012 Data SHALL be sampled in the grant cycle; a requester SHALL hold req and data_in stable until granted.
REQ-013 Latency SHALL be one cycle: on the edge after a grant to i, res_valid=1, res_id=i, and res_data=the sum (or accumulator value per REQ-018).
REQ-014 FSM transitions:
- EMPTY, grant -> FULL.
- FULL, res_ready=1 with no grant -> EMPTY.
- FULL, res_ready=1 with a grant -> FULL with new result (back-to-back).
- FULL, res_ready=0 -> FULL; res_id and res_data stable; gnt=0.
REQ-015 Sustained throughput SHALL be one result per cycle while res_ready=1 and any req is set.
REQ-016 res_data and res_id SHALL change only on a grant edge or on reset.

Reset
REQ-017 Asserting reset (low) SHALL immediately clear the following; no pending result survives reset, and gnt=0 while reset is asserted:
- res_valid=0, res_id=0, res_data=0, ptr=0.
- all accumulators, when present.

Configuration
REQ-018 Macro C_ADD_SCHED_ACCUM_EN, when defined:
- Each requester SHALL have an acc_width accumulator acc[i].
- On a grant to i, acc[i] SHALL become acc[i]+sum, wrapping modulo 2^acc_width, and res_data SHALL equal the new acc[i].
- acc_clr[i] SHALL zero acc[i] synchronously.
- Simultaneous acc_clr[i] and grant to i SHALL give acc[i]=sum (clear applied first).
REQ-019 Without the macro: no accumulators, no acc_clr port, and res_data SHALL equal the raw sum of width out_width.

Verification (width=4, num_ports=2, num_reqs=4)
REQ-020 Bench SHALL cover these scenarios:
- Reset release; req=1000 (req[0] set), operands {3,5}, res_ready=1 -> gnt[0] same cycle; next edge res_valid=1, res_id=0, res_data=8.
- All req held, res_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; res_valid high continuously.
- res_valid=1 with res_ready=0 for 3 cycles -> gnt=0 and res_data stable; res_ready=1 -> grant in that same cycle, new result next edge.
- Operands {15,15} -> res_data=30, out_width=5.
- reset low mid-stream with res_valid=1 -> res_valid=0 with no clock edge; after release the first grant goes to req[0].
- C_ADD_SCHED_ACCUM_EN, requester 0 summing 8 three times -> 8, 16, 24; acc_clr[0] with grant -> 8; acc_width=4 with sum 8 twice -> 8, then 0 (wrap).
